mpadder_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 128-bit multi-precision adder (start/done handshake, 129-bit result) between two requesters. It accepts one operand pair at a time, latches it, issues a single start pulse to the adder and waits for done. It then returns the 129-bit sum tagged with the requester id. It sits between the software-facing operand ports and the shared mpadder instance.

---
 rtl/mpadder_arbiter.sv | 150 +++++++++++++++
 tb/tb_mpadder_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mpadder_arbiter.sv
// Round-robin sequencer sharing one 128-bit multi-precision adder between two requesters.
// Optional WAIT-state abort is compiled in with `define MPARB_TIMEOUT_EN.
module mpadder_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         req0_valid,
  input  logic [127:0] req0_a,
  input  logic [127:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [127:0] req1_a,
  input  logic [127:0] req1_b,
  output logic         req1_ready,
  output logic         add_start,
  output logic [127:0] add_a,
  output logic [127:0] add_b,
  input  logic [128:0] add_c,
  input  logic         add_done,
  output logic         res_valid,
  output logic         res_id,
  output logic [128:0] res_c,
  output logic         res_err,
  output logic [1:0]   dbg_state
);

  // Handshake: a requester's operands transfer on the rising edge where valid && ready.
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [15:0] TERM_CNT = 16'(TIMEOUT_CYCLES - 1);

  state_t       state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic         owner_q, owner_d;
  logic         add_start_q, add_start_d;
  logic [127:0] add_a_q, add_a_d;
  logic [127:0] add_b_q, add_b_d;
  logic         res_valid_q, res_valid_d;
  logic         res_id_q, res_id_d;
  logic [128:0] res_c_q, res_c_d;
  logic         res_err_q, res_err_d;
  logic         grant_id;
  logic         xfer;
  logic         timeout_hit;

  // Contention goes to the requester that did not own the previous result.
  always_comb begin
    grant_id = 1'b1;
    if (req0_valid) grant_id = req1_valid ? ~last_grant_q : 1'b0;
    xfer = (state_q == S_IDLE) && (req0_valid || req1_valid);
  end

  assign req0_ready = (state_q == S_IDLE) && req0_valid && (grant_id == 1'b0);
  assign req1_ready = (state_q == S_IDLE) && req1_valid && (grant_id == 1'b1);

`ifdef MPARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb cnt_d = (state_q == S_WAIT) ? cnt_q + 16'd1 : 16'd0;

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= 16'd0;
    else         cnt_q <= cnt_d;
  end

  assign timeout_hit = (state_q == S_WAIT) && !add_done && (cnt_q == TERM_CNT);
`else
  logic unused_timeout;
  assign unused_timeout = ^TERM_CNT;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      add_start_q  <= 1'b0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      res_valid_q  <= 1'b0;
      res_id_q     <= 1'b0;
      res_c_q      <= '0;
      res_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      add_start_q  <= add_start_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_c_q      <= res_c_d;
      res_err_q    <= res_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (xfer) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (add_done || timeout_hit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pulses are registered from the next state so they line up with ISSUE and RESP.
  always_comb begin
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    add_a_d      = add_a_q;
    add_b_d      = add_b_q;
    res_id_d     = res_id_q;
    res_c_d      = res_c_q;
    res_err_d    = res_err_q;
    add_start_d  = (state_d == S_ISSUE);
    res_valid_d  = (state_d == S_RESP);
    if (xfer) begin
      owner_d = grant_id;
      add_a_d = grant_id ? req1_a : req0_a;
      add_b_d = grant_id ? req1_b : req0_b;
    end
    if (state_q == S_WAIT) begin
      if (add_done) begin
        res_c_d   = add_c;
        res_err_d = 1'b0;
        res_id_d  = owner_q;
      end else if (timeout_hit) begin
        res_c_d   = '0;
        res_err_d = 1'b1;
        res_id_d  = owner_q;
      end
    end
    if (state_q == S_RESP) last_grant_d = owner_q;
  end

  assign add_start = add_start_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_c     = res_c_q;
  assign res_err   = res_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mpadder_arbiter.sv
// Directed plus randomized bench for mpadder_arbiter; the bench plays the shared adder.
module tb_mpadder_arbiter;

  logic         clk = 1'b0;
  logic         resetn;
  logic         req0_valid, req1_valid;
  logic [127:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         add_start;
  logic [127:0] add_a, add_b;
  logic [128:0] add_c;
  logic         add_done;
  logic         res_valid, res_id, res_err;
  logic [128:0] res_c;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic m_last;  // reference model: owner of the most recent result (1 after reset)

  always #5 clk = ~clk;

  mpadder_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .add_start(add_start), .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_done(add_done),
    .res_valid(res_valid), .res_id(res_id), .res_c(res_c), .res_err(res_err),
    .dbg_state(dbg_state)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One operation: present requests, play the adder with latency lat, check the response.
  task automatic run_op(input logic v0, input logic v1,
                        input logic [127:0] a0, input logic [127:0] b0,
                        input logic [127:0] a1, input logic [127:0] b1,
                        input int lat, input logic spur);
    logic         g;
    logic [127:0] ea, eb;
    logic [128:0] sum;
    g   = (v0 && v1) ? ~m_last : v1;
    ea  = g ? a1 : a0;
    eb  = g ? b1 : b0;
    sum = {1'b0, ea} + {1'b0, eb};
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    #1;
    chk("req0_ready", {128'b0, req0_ready}, {128'b0, ~g});
    chk("req1_ready", {128'b0, req1_ready}, {128'b0, g});
    chk("one_ready", {128'b0, req0_ready ^ req1_ready}, 129'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = rnd128(); req1_a = rnd128(); req0_b = rnd128(); req1_b = rnd128();
    chk("add_start_pulse", {128'b0, add_start}, 129'd1);
    chk("add_a", {1'b0, add_a}, {1'b0, ea});
    chk("add_b", {1'b0, add_b}, {1'b0, eb});
    chk("res_valid_issue", {128'b0, res_valid}, 129'd0);
    add_done = 1'b0;
    if (spur) begin
      add_done = 1'b1;
      add_c    = {1'b1, rnd128()};
    end
    for (int i = 0; i < lat; i++) begin
      tick();
      add_done = 1'b0;
      chk("add_start_wait", {128'b0, add_start}, 129'd0);
      chk("res_valid_wait", {128'b0, res_valid}, 129'd0);
      chk("add_a_hold", {1'b0, add_a}, {1'b0, ea});
      if (i == lat - 1) begin
        add_done = 1'b1;
        add_c    = sum;
      end
    end
    tick();
    add_done = 1'b0;
    add_c    = {1'b0, rnd128()};
    chk("res_valid", {128'b0, res_valid}, 129'd1);
    chk("res_id", {128'b0, res_id}, {128'b0, g});
    chk("res_c", res_c, sum);
    chk("res_err", {128'b0, res_err}, 129'd0);
    m_last = g;
    tick();
    chk("res_valid_low", {128'b0, res_valid}, 129'd0);
    chk("res_c_hold", res_c, sum);
    chk("res_id_hold", {128'b0, res_id}, {128'b0, g});
  endtask

  initial begin
    resetn = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    add_c = '0; add_done = 1'b0;
    m_last = 1'b1;
    tick(); tick();
    chk("rst_add_start", {128'b0, add_start}, 129'd0);
    chk("rst_add_a", {1'b0, add_a}, 129'd0);
    chk("rst_add_b", {1'b0, add_b}, 129'd0);
    chk("rst_res_valid", {128'b0, res_valid}, 129'd0);
    chk("rst_res_id", {128'b0, res_id}, 129'd0);
    chk("rst_res_c", res_c, 129'd0);
    chk("rst_res_err", {128'b0, res_err}, 129'd0);
    resetn = 1'b1;
    tick();
    chk("idle_no_ready", {127'b0, req0_ready, req1_ready}, 129'd0);

    // Test 1 and 2: single requests, including the carry out of bit 127.
    run_op(1'b1, 1'b0, 128'h1, 128'h2, '0, '0, 3, 1'b0);
    chk("t1_sum", res_c, 129'h3);
    run_op(1'b0, 1'b1, '0, '0, {128{1'b1}}, 128'h1, 2, 1'b0);
    chk("t2_sum", res_c, {1'b1, 128'h0});

    // Test 3: both requesters continuously pending.
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, 1'b1, rnd128(), rnd128(), rnd128(), rnd128(), $urandom_range(1, 4), 1'b0);
      chk("t3_order", {128'b0, res_id}, {128'b0, (i % 2 == 1)});
    end

    // Test 4: done pulses outside WAIT are ignored.
    add_done = 1'b1; add_c = {1'b1, rnd128()};
    tick();
    add_done = 1'b0;
    tick();
    chk("t4_idle_done", {128'b0, res_valid}, 129'd0);
    run_op(1'b1, 1'b0, rnd128(), rnd128(), rnd128(), rnd128(), 2, 1'b1);
    run_op(1'b1, 1'b1, rnd128(), rnd128(), rnd128(), rnd128(), 1, 1'b1);

    // Test 5: reset while waiting for the adder, then a late done.
    req0_valid = 1'b1; req0_a = rnd128(); req0_b = rnd128();
    tick();
    req0_valid = 1'b0;
    tick(); tick();
    resetn = 1'b0;
    tick();
    chk("t5_add_start", {128'b0, add_start}, 129'd0);
    chk("t5_add_a", {1'b0, add_a}, 129'd0);
    chk("t5_add_b", {1'b0, add_b}, 129'd0);
    chk("t5_res_valid", {128'b0, res_valid}, 129'd0);
    chk("t5_res_id", {128'b0, res_id}, 129'd0);
    chk("t5_res_c", res_c, 129'd0);
    chk("t5_res_err", {128'b0, res_err}, 129'd0);
    resetn = 1'b1;
    m_last = 1'b1;
    add_done = 1'b1; add_c = {1'b1, rnd128()};
    run_op(1'b1, 1'b1, rnd128(), rnd128(), rnd128(), rnd128(), 3, 1'b0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 24; n++) begin
      logic v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      run_op(v0, v1, rnd128(), rnd128(), rnd128(), rnd128(), $urandom_range(1, 5), 1'($urandom_range(0, 1)));
    end

    // Done arriving on the last allowed WAIT cycle is a normal completion in either build.
    run_op(1'b0, 1'b1, rnd128(), rnd128(), rnd128(), rnd128(), 8, 1'b0);

    // Test 6: the adder never answers.
    req0_valid = 1'b1; req0_a = rnd128(); req0_b = rnd128();
    #1;
    chk("t6_ready", {128'b0, req0_ready}, 129'd1);
    tick();
    req0_valid = 1'b0;
    chk("t6_start", {128'b0, add_start}, 129'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t6_wait", {128'b0, res_valid}, 129'd0);
    end
`ifdef MPARB_TIMEOUT_EN
    tick();
    chk("t6_res_valid", {128'b0, res_valid}, 129'd1);
    chk("t6_res_err", {128'b0, res_err}, 129'd1);
    chk("t6_res_c", res_c, 129'd0);
    chk("t6_res_id", {128'b0, res_id}, 129'd0);
    m_last = 1'b0;
    tick();
    chk("t6_err_hold", {128'b0, res_err}, 129'd1);
    run_op(1'b1, 1'b1, rnd128(), rnd128(), rnd128(), rnd128(), 2, 1'b0);
    chk("t6_err_clear", {128'b0, res_err}, 129'd0);
`else
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("t6_no_result", {128'b0, res_valid}, 129'd0);
    end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    m_last = 1'b1;
    run_op(1'b1, 1'b1, rnd128(), rnd128(), rnd128(), rnd128(), 2, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
